// File: rtl/matmul_sequencer.sv
// Sequences one element-wise operand stream (R-inverse x Q-transpose) through the multiplier
// and collects the results. Optional result watchdog: define MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer #(
  parameter int unsigned WORDLEN            = 16,
  parameter int unsigned FRACTION_WIDTH     = 12,
  parameter int unsigned MATRIX_ELEMENT_NUM = 9,
  parameter int unsigned ISSUE_GAP          = 1,
  parameter int unsigned ADDR_W             = $clog2(MATRIX_ELEMENT_NUM),
  parameter int unsigned TIMEOUT_CYCLES     = 64
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               a_rd_en,
  output logic [ADDR_W-1:0]  a_rd_addr,
  input  logic [WORDLEN-1:0] a_rd_data,
  output logic               b_rd_en,
  output logic [ADDR_W-1:0]  b_rd_addr,
  input  logic [WORDLEN-1:0] b_rd_data,
  output logic               valid_mul,
  output logic [WORDLEN-1:0] r_mat_inv,
  output logic [WORDLEN-1:0] transpose_out,
  input  logic               done_mul,
  input  logic [WORDLEN-1:0] mul_out,
  output logic               res_wr_en,
  output logic [ADDR_W-1:0]  res_wr_addr,
  output logic [WORDLEN-1:0] res_wr_data
);

  localparam int unsigned CntW = $clog2(MATRIX_ELEMENT_NUM + 1);
  localparam int unsigned GapW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [CntW-1:0] NumEl   = CntW'(MATRIX_ELEMENT_NUM);
  localparam logic [CntW-1:0] LastIdx = CntW'(MATRIX_ELEMENT_NUM - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

  if (FRACTION_WIDTH >= WORDLEN || TIMEOUT_CYCLES == 0 || MATRIX_ELEMENT_NUM == 0)
  begin : g_cfg_check
    $error("matmul_sequencer: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StGap,
    StDrain,
    StDone
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    issue_cnt_q;
  logic [CntW-1:0]    res_cnt_q;
  logic [GapW-1:0]    gap_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;
  logic               valid_mul_q;
  logic [WORDLEN-1:0] op_a_q;
  logic [WORDLEN-1:0] op_b_q;
  logic               res_wr_en_q;
  logic [CntW-1:0]    res_wr_addr_q;
  logic [WORDLEN-1:0] res_wr_data_q;
  logic               collect;
  logic               wd_fire;

  // Results are accepted while a job is live and slots remain.
  assign collect = (state_q != StIdle) && (state_q != StDone) && done_mul &&
                   (res_cnt_q != NumEl);

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q;
  logic           error_q;

  // wd_q counts cycles since the last done_mul, including the cycle it arrived in.
  assign wd_fire = (state_q == StDrain) && !done_mul && (res_cnt_q != NumEl) &&
                   (wd_q >= WdLimit);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else if (state_q == StIdle) begin
      wd_q <= '0;
      if (start) begin
        error_q <= 1'b0;
      end
    end else begin
      if (done_mul) begin
        wd_q <= WdW'(1);
      end else if (wd_q < WdLimit) begin
        wd_q <= wd_q + 1'b1;
      end
      if (wd_fire) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q       <= StIdle;
      issue_cnt_q   <= '0;
      res_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      valid_mul_q   <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      res_wr_en_q   <= 1'b0;
      res_wr_addr_q <= '0;
      res_wr_data_q <= '0;
    end else begin
      rd_en_q     <= 1'b0;
      valid_mul_q <= 1'b0;
      done_q      <= 1'b0;
      res_wr_en_q <= 1'b0;

      if (collect) begin
        res_wr_en_q   <= 1'b1;
        res_wr_addr_q <= res_cnt_q;
        res_wr_data_q <= mul_out;
        res_cnt_q     <= res_cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StFetch;
            issue_cnt_q <= '0;
            res_cnt_q   <= '0;
            busy_q      <= 1'b1;
            rd_en_q     <= 1'b1;
          end
        end
        StFetch: begin
          state_q <= StLoad;
        end
        StLoad: begin
          op_a_q      <= a_rd_data;
          op_b_q      <= b_rd_data;
          valid_mul_q <= 1'b1;
          state_q     <= StIssue;
        end
        StIssue: begin
          issue_cnt_q <= issue_cnt_q + 1'b1;
          if (ISSUE_GAP != 0) begin
            state_q   <= StGap;
            gap_cnt_q <= '0;
          end else if (issue_cnt_q == LastIdx) begin
            state_q <= StDrain;
          end else begin
            state_q <= StFetch;
            rd_en_q <= 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            if (issue_cnt_q == NumEl) begin
              state_q <= StDrain;
            end else begin
              state_q <= StFetch;
              rd_en_q <= 1'b1;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (res_cnt_q == NumEl || wd_fire) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign a_rd_en       = rd_en_q;
  assign b_rd_en       = rd_en_q;
  assign a_rd_addr     = ADDR_W'(issue_cnt_q);
  assign b_rd_addr     = ADDR_W'(issue_cnt_q);
  assign valid_mul     = valid_mul_q;
  assign r_mat_inv     = op_a_q;
  assign transpose_out = op_b_q;
  assign res_wr_en     = res_wr_en_q;
  assign res_wr_addr   = ADDR_W'(res_wr_addr_q);
  assign res_wr_data   = res_wr_data_q;

endmodule
